inv_perm_sequencer: RTL

//  Sequences undo-permutation of a DxD frame held in a two-bank pixel buffer.

---
 rtl/inv_perm_sequencer_if.sv | 46 ++++
 rtl/inv_perm_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/inv_perm_sequencer_if.sv
// Handshake and memory-port bundle between the inverse-permutation sequencer,
// the decryption top level (start/abort/busy/done) and the frame/key RAMs.
interface inv_perm_sequencer_if #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned PIX_W = 8
);
  // Control handshake
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  // Key RAM port
  logic             key_rd;
  logic             key_sel;
  logic [DIM_W-1:0] key_addr;
  logic [DIM_W-1:0] key_rdata;
  // Source pixel read port
  logic             src_rd;
  logic             src_bank;
  logic [DIM_W-1:0] src_row;
  logic [DIM_W-1:0] src_col;
  logic [PIX_W-1:0] src_rdata;
  // Destination pixel write port
  logic             dst_wr;
  logic             dst_bank;
  logic [DIM_W-1:0] dst_row;
  logic [DIM_W-1:0] dst_col;
  logic [PIX_W-1:0] dst_wdata;
  logic             dst_ready;

  // Sequencer side
  modport master (
    input  start, abort, key_rdata, src_rdata, dst_ready,
    output busy, done, key_rd, key_sel, key_addr,
    output src_rd, src_bank, src_row, src_col,
    output dst_wr, dst_bank, dst_row, dst_col, dst_wdata
  );

  // Top-level / RAM side
  modport slave (
    output start, abort, key_rdata, src_rdata, dst_ready,
    input  busy, done, key_rd, key_sel, key_addr,
    input  src_rd, src_bank, src_row, src_col,
    input  dst_wr, dst_bank, dst_row, dst_col, dst_wdata
  );
endinterface

// File: rtl/inv_perm_sequencer.sv
// Two-pass undo-permutation sequencer for a DxD frame in a two-bank buffer.
// Pass 1 unshifts columns (bank 0 -> bank 1), pass 2 unshifts rows (bank 1 -> bank 0).
// Each line fetches its shift key, then streams D reads; writes trail reads by one cycle.
module inv_perm_sequencer #(
  parameter int unsigned DIM_W = 8,
  parameter int unsigned PIX_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_perm_sequencer_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StKey,
    StKwait,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             pass_q, pass_d;    // 0 = column pass, 1 = row pass
  logic [DIM_W-1:0] line_q, line_d;
  logic [DIM_W-1:0] idx_q, idx_d;
  logic [DIM_W-1:0] shift_q, shift_d;
  logic             wr_q, wr_d;
  logic             wr_bank_q, wr_bank_d;
  logic [DIM_W-1:0] wr_row_q, wr_row_d;
  logic [DIM_W-1:0] wr_col_q, wr_col_d;

  logic             stall;
  logic             run_rd;
  logic             last_idx;
  logic             last_line;
  logic [DIM_W-1:0] shifted;
  logic [PIX_W-1:0] wdata;

  // A refused write freezes the whole sequencer so the pending write can retry.
  assign stall     = wr_q & ~bus_io.dst_ready;
  assign run_rd    = (state_q == StRun) & ~stall;
  assign last_idx  = (idx_q == {DIM_W{1'b1}});
  assign last_line = (line_q == {DIM_W{1'b1}});
  // Modulo-D subtraction by natural wrap of the DIM_W-bit result.
  assign shifted   = idx_q - shift_q;

  // Next-state logic: abort beats everything, stall holds everything else.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    line_d    = line_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    wr_d      = wr_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;

    if (bus_io.abort) begin
      state_d = StIdle;
      wr_d    = 1'b0;
    end else if (!stall) begin
      wr_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_d = StKey;
            pass_d  = 1'b0;
            line_d  = '0;
          end
        end
        StKey:   state_d = StKwait;
        StKwait: begin
          shift_d = bus_io.key_rdata;
          idx_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          // Queue the write that pairs with this cycle's read.
          wr_d      = 1'b1;
          wr_bank_d = ~pass_q;
          wr_row_d  = pass_q ? line_q : idx_q;
          wr_col_d  = pass_q ? idx_q : line_q;
          idx_d     = idx_q + 1'b1;
          if (last_idx) begin
            if (!last_line) begin
              line_d  = line_q + 1'b1;
              state_d = StKey;
            end else if (!pass_q) begin
              pass_d  = 1'b1;
              line_d  = '0;
              state_d = StKey;
            end else begin
              state_d = StDrain;
            end
          end
        end
        StDrain: state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pass_q    <= 1'b0;
      line_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      wr_q      <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      line_q    <= line_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      wr_q      <= wr_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
    end
  end

  // Read data from the previous cycle is held by the RAM while src_rd is low.
  assign wdata = wr_q ? bus_io.src_rdata : '0;

  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.key_rd    = (state_q == StKey) & ~stall;
  assign bus_io.key_sel   = pass_q;
  assign bus_io.key_addr  = line_q;
  assign bus_io.src_rd    = run_rd;
  assign bus_io.src_bank  = run_rd & pass_q;
  assign bus_io.src_row   = run_rd ? (pass_q ? line_q : shifted) : '0;
  assign bus_io.src_col   = run_rd ? (pass_q ? shifted : line_q) : '0;
  assign bus_io.dst_wr    = wr_q;
  assign bus_io.dst_bank  = wr_bank_q;
  assign bus_io.dst_row   = wr_row_q;
  assign bus_io.dst_col   = wr_col_q;
  assign bus_io.dst_wdata = wdata;

endmodule
